pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline stage for the CPU datapath (first use: MEM→WB boundary).
- Carries NUM_DATA data lanes (e.g. load data, ALU result), a control field (e.g. mem2reg, reg_write) and a destination register index.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never creates a combinational ready path through the stage.
- Adds synchronous flush and bubble-safe control: control bits are forced to 0 whenever the output is not valid.

---
 rtl/pipe_stage_skid.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Elastic pipeline stage with a two-entry skid buffer. It
//                carries NUM_DATA data lanes, a control field and a
//                destination register index across a valid/ready boundary.
//                in_ready depends only on registered state, and no input
//                reaches an output through combinational logic.
//                out_ctrl and out_rd are masked by out_valid, so a bubble
//                never asserts write-enable style control bits.
//  Ports       :
//      clk        - clock, rising edge
//      rst        - asynchronous active-high reset
//      flush      - synchronous flush, discards every held entry
//      in_valid   - upstream entry valid
//      in_ready   - stage can accept an entry this cycle
//      in_data    - NUM_DATA lanes, lane 0 in the LSBs
//      in_ctrl    - control field
//      in_rd      - destination register index
//      out_valid  - head entry valid
//      out_ready  - downstream accepts the head entry
//      out_data   - head data lanes
//      out_ctrl   - head control, 0 when out_valid = 0
//      out_rd     - head destination index, 0 when out_valid = 0
//      occupancy  - number of held entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int CTRL_W   = 2,
    parameter int RD_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd,
    output logic [1:0]                 occupancy
);

    localparam int c_LANES_W = NUM_DATA * DATA_W;

    // State encoding doubles as the entry count.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    // Head entry (drives the outputs) and second entry.
    logic [c_LANES_W-1:0] r_main_data;
    logic [CTRL_W-1:0]    r_main_ctrl;
    logic [RD_W-1:0]      r_main_rd;
    logic [c_LANES_W-1:0] r_skid_data;
    logic [CTRL_W-1:0]    r_skid_ctrl;
    logic [RD_W-1:0]      r_skid_rd;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [1:0]           w_occupancy;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_load_main_in;
    logic                 w_load_main_skid;
    logic                 w_load_skid;

    // ------------------------------------------------------------------
    // Handshake events. Both are built from registered-state signals
    // AND'ed with the external strobe, so neither feeds back into
    // in_ready or out_valid.
    // ------------------------------------------------------------------
    assign w_accept  = in_valid  & w_in_ready;
    assign w_release = w_out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides every handshake event.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && !w_release) begin
                        w_state_nxt = c_ST_FULL;
                    end else if (!w_accept && w_release) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_release) begin
                        w_state_nxt = c_ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-derived outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
        case (r_state)
            c_ST_EMPTY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
                w_occupancy = 2'd0;
            end
            c_ST_ONE: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b1;
                w_occupancy = 2'd1;
            end
            c_ST_FULL: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
                w_occupancy = 2'd2;
            end
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
                w_occupancy = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load enables. A new entry goes to the head when the stage is empty,
    // or when the single held entry leaves in the same cycle. It goes to
    // the skid slot only when the head is stalled. When full, a release
    // promotes the skid entry; in_ready is low so nothing new arrives.
    // ------------------------------------------------------------------
    assign w_load_main_in   = w_accept &&
                              ((r_state == c_ST_EMPTY) ||
                               ((r_state == c_ST_ONE) && w_release));
    assign w_load_main_skid = (r_state == c_ST_FULL) && w_release;
    assign w_load_skid      = w_accept && (r_state == c_ST_ONE) && !w_release;

    // ------------------------------------------------------------------
    // Entry storage. Flush clears only the control and index fields; the
    // stale data is harmless because the entries are marked invalid and
    // ctrl/rd are masked at the outputs anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_main_rd   <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_rd   <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_main_rd   <= '0;
            r_skid_ctrl <= '0;
            r_skid_rd   <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
                r_main_rd   <= in_rd;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
                r_main_rd   <= r_skid_rd;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
                r_skid_rd   <= in_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign occupancy = w_occupancy;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign out_rd    = r_main_rd   & {RD_W{w_out_valid}};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Directed self-checking bench for pipe_stage_skid with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage_skid;

    localparam int c_DATA_W   = 32;
    localparam int c_NUM_DATA = 2;
    localparam int c_CTRL_W   = 2;
    localparam int c_RD_W     = 5;

    logic                           clk;
    logic                           rst;
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [c_NUM_DATA*c_DATA_W-1:0] in_data;
    logic [c_CTRL_W-1:0]            in_ctrl;
    logic [c_RD_W-1:0]              in_rd;
    logic                           out_valid;
    logic                           out_ready;
    logic [c_NUM_DATA*c_DATA_W-1:0] out_data;
    logic [c_CTRL_W-1:0]            out_ctrl;
    logic [c_RD_W-1:0]              out_rd;
    logic [1:0]                     occupancy;

    int n_tests;
    int n_fail;

    pipe_stage_skid #(
        .DATA_W   (c_DATA_W),
        .NUM_DATA (c_NUM_DATA),
        .CTRL_W   (c_CTRL_W),
        .RD_W     (c_RD_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] c,
                         input logic [4:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11, 5'd31);

        // ---------------- 1. reset / pass-through ----------------
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_out_rd",    64'(out_rd),    64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occ",       64'(occupancy), 64'd0);

        out_ready = 1'b1;
        drive(1'b1, {32'h0000_00AA, 32'h1234_5678}, 2'b01, 5'd5);
        step();
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("pt_out_valid", 64'(out_valid), 64'd1);
        check("pt_out_data",  out_data,       {32'h0000_00AA, 32'h1234_5678});
        check("pt_out_ctrl",  64'(out_ctrl),  64'd1);
        check("pt_out_rd",    64'(out_rd),    64'd5);
        check("pt_occ",       64'(occupancy), 64'd1);
        step();
        check("pt_drain_valid", 64'(out_valid), 64'd0);
        check("pt_drain_rd",    64'(out_rd),    64'd0);

        // ---------------- 2. backpressure / skid ----------------
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 2'b01, 5'd1);
        step();
        check("bp_a_occ",   64'(occupancy), 64'd1);
        check("bp_a_ready", 64'(in_ready),  64'd1);
        drive(1'b1, 64'hB, 2'b10, 5'd2);
        step();
        check("bp_b_occ",   64'(occupancy), 64'd2);
        check("bp_b_ready", 64'(in_ready),  64'd0);
        check("bp_b_head",  out_data,       64'hA);
        drive(1'b1, 64'hC, 2'b11, 5'd3);
        step();
        check("bp_c_occ",   64'(occupancy), 64'd2);
        check("bp_c_head",  out_data,       64'hA);
        check("bp_c_rd",    64'(out_rd),    64'd1);
        out_ready = 1'b1;
        #1;
        check("bp_out0", out_data, 64'hA);
        step();
        check("bp_out1",     out_data,       64'hB);
        check("bp_out1_rd",  64'(out_rd),    64'd2);
        check("bp_out1_occ", 64'(occupancy), 64'd1);
        step();
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("bp_out2",     out_data,       64'hC);
        check("bp_out2_ctl", 64'(out_ctrl),  64'd3);
        check("bp_out2_occ", 64'(occupancy), 64'd1);
        step();
        check("bp_done_valid", 64'(out_valid), 64'd0);

        // ---------------- 3. streaming ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'(i), 2'b01, 5'(i));
            step();
            check("st_data",  out_data,       64'(i));
            check("st_occ",   64'(occupancy), 64'd1);
            check("st_ready", 64'(in_ready),  64'd1);
        end
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        step();
        check("st_done_occ", 64'(occupancy), 64'd0);

        // ---------------- 4. flush priority ----------------
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 2'b11, 5'd9);
        step();
        drive(1'b1, 64'h22, 2'b11, 5'd10);
        step();
        check("fl_full_occ",  64'(occupancy), 64'd2);
        check("fl_full_ctrl", 64'(out_ctrl),  64'd3);
        flush = 1'b1;
        drive(1'b1, 64'hBAD, 2'b11, 5'd17);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        check("fl_no_x", 64'(out_valid), 64'd0);
        // Flush while one entry is held and a new entry is accepted.
        drive(1'b1, 64'h33, 2'b01, 5'd4);
        step();
        check("fl1_occ", 64'(occupancy), 64'd1);
        flush = 1'b1;
        drive(1'b1, 64'hBAD, 2'b11, 5'd17);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("fl1_valid", 64'(out_valid), 64'd0);
        check("fl1_occ0",  64'(occupancy), 64'd0);
        step();
        check("fl1_no_x", 64'(out_valid), 64'd0);

        // ---------------- 5. bubble gating ----------------
        out_ready = 1'b1;
        drive(1'b1, 64'h44, 2'b01, 5'd7);
        step();
        check("bb_v1",    64'(out_valid), 64'd1);
        check("bb_ctrl1", 64'(out_ctrl),  64'd1);
        check("bb_rd1",   64'(out_rd),    64'd7);
        drive(1'b0, 64'h0, 2'b01, 5'd7);
        step();
        check("bb_v0",    64'(out_valid), 64'd0);
        check("bb_ctrl0", 64'(out_ctrl),  64'd0);
        check("bb_rd0",   64'(out_rd),    64'd0);
        drive(1'b1, 64'h55, 2'b01, 5'd8);
        step();
        check("bb_v2",    64'(out_valid), 64'd1);
        check("bb_ctrl2", 64'(out_ctrl),  64'd1);
        check("bb_rd2",   64'(out_rd),    64'd8);
        check("bb_data2", out_data,       64'h55);
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        step();
        check("bb_v3",    64'(out_valid), 64'd0);
        check("bb_ctrl3", 64'(out_ctrl),  64'd0);

        // ---------------- 6. async reset mid-stream ----------------
        out_ready = 1'b0;
        drive(1'b1, 64'h66, 2'b11, 5'd12);
        step();
        drive(1'b1, 64'h77, 2'b11, 5'd13);
        step();
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("ar_pre_occ", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ctrl",  64'(out_ctrl),  64'd0);
        check("ar_occ",   64'(occupancy), 64'd0);
        check("ar_data",  out_data,       64'd0);
        check("ar_ready", 64'(in_ready),  64'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 64'h88, 2'b01, 5'd14);
        step();
        drive(1'b0, 64'h0, 2'b00, 5'd0);
        check("ar_post_valid", 64'(out_valid), 64'd1);
        check("ar_post_data",  out_data,       64'h88);
        check("ar_post_rd",    64'(out_rd),    64'd14);
        step();
        check("ar_post_drain", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
